// File: rtl/shift_rot_unit.sv
// Iterative shift/rotate engine: one power-of-two barrel stage per clock,
// valid/ready handshakes on request and result sides.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   BUSY  | applying stage cnt (distance 2^cnt) when amt[cnt] is set
//   DONE  | result presented, waiting for out_ready
module shift_rot_unit #(
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;

  localparam logic [AW-1:0] LAST_STAGE = AW'(AW - 1);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [AW-1:0]      amt;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      stage_dist;
  logic [1:0]         mode;
  logic [2*WIDTH-1:0] dbl_l;
  logic [2*WIDTH-1:0] dbl_r;

  // Rotates come from shifting the operand concatenated with itself.
  always_comb begin
    stage_dist = AW'(1) << cnt;
    dbl_l      = {acc, acc} << stage_dist;
    dbl_r      = {acc, acc} >> stage_dist;
    acc_nxt    = acc;
    if (amt[cnt]) begin
      case (mode)
        MODE_SLL: acc_nxt = acc << stage_dist;
        MODE_SRL: acc_nxt = acc >> stage_dist;
        MODE_ROL: acc_nxt = dbl_l[2*WIDTH-1:WIDTH];
        default:  acc_nxt = dbl_r[WIDTH-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      amt       <= '0;
      cnt       <= '0;
      mode      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= in_data;
            amt      <= in_amount;
            mode     <= in_mode;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + AW'(1);
          if (cnt == LAST_STAGE) begin
            // out_data is its own register so it survives the next accept.
            out_data  <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rot_unit.sv
// Directed bench for shift_rot_unit at WIDTH=32: latency, modes, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_shift_rot_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  shift_rot_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for its accept edge, then count edges to out_valid.
  task automatic send(input string tag, input logic [31:0] d, input logic [4:0] a,
                      input logic [1:0] m, input logic [31:0] exp);
    logic taken;
    int   n;
    int   lat;
    in_data   = d;
    in_amount = a;
    in_mode   = m;
    in_valid  = 1'b1;
    n = 0;
    do begin
      taken = in_ready;
      tick();
      n++;
    end while (!taken && n < 50);
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(taken), 32'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          pulses;
    int          na;
    int          nh;
    int          acc_cyc [2];
    logic [31:0] b2b_op  [2];
    logic [4:0]  b2b_amt [2];
    logic [1:0]  b2b_md  [2];
    logic [31:0] b2b_exp [2];
    logic        acc_now;
    logic        hs_now;
    logic [31:0] hs_data;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    send("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000); drain("sll31");
    send("srl4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000);   drain("srl4");
    send("srl31", 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001); drain("srl31");
    send("amt0_sll", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF); drain("amt0_sll");
    send("amt0_ror", 32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF); drain("amt0_ror");
    send("rol8", 32'h1234_5678, 5'd8, 2'b10, 32'h3456_7812);   drain("rol8");
    send("ror8", 32'h1234_5678, 5'd8, 2'b11, 32'h7812_3456);   drain("ror8");
    send("rol1", 32'h8000_0001, 5'd1, 2'b10, 32'h0000_0003);   drain("rol1");
    send("ror1", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000);   drain("ror1");
    send("sll5", 32'h0000_00FF, 5'd5, 2'b00, 32'h0000_1FE0);   drain("sll5");

    // Backpressure with a competing request held on the input.
    send("bp", 32'h1234_5678, 5'd4, 2'b10, 32'h2345_6781);
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_F00D;
    in_amount = 5'd3;
    in_mode   = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", out_data, 32'h2345_6781);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");
    chk("bp_data_after", out_data, 32'h2345_6781);

    // Reset two edges after the accept edge.
    send_no_wait(32'hFFFF_0000, 5'd7, 2'b11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
    send("post_rst", 32'h00F0_0000, 5'd12, 2'b01, 32'h0000_0F00); drain("post_rst");

    // Back-to-back with in_valid and out_ready held high.
    b2b_op[0] = 32'h0F0F_0000; b2b_amt[0] = 5'd8; b2b_md[0] = 2'b01; b2b_exp[0] = 32'h000F_0F00;
    b2b_op[1] = 32'hA5A5_A5A5; b2b_amt[1] = 5'd1; b2b_md[1] = 2'b11; b2b_exp[1] = 32'hD2D2_D2D2;
    na = 0;
    nh = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    in_data   = b2b_op[0];
    in_amount = b2b_amt[0];
    in_mode   = b2b_md[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      hs_data = out_data;
      tick();
      if (acc_now) begin
        acc_cyc[na] = c;
        na++;
        if (na < 2) begin
          in_data   = b2b_op[na];
          in_amount = b2b_amt[na];
          in_mode   = b2b_md[na];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (hs_now) begin
        if (nh < 2) chk("b2b_data", hs_data, b2b_exp[nh]);
        nh++;
      end
    end
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd2);
    chk("b2b_handshakes", 32'(nh), 32'd2);
    chk("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic send_no_wait(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    logic taken;
    int   n;
    in_data   = d;
    in_amount = a;
    in_mode   = m;
    in_valid  = 1'b1;
    n = 0;
    do begin
      taken = in_ready;
      tick();
      n++;
    end while (!taken && n < 50);
    in_valid = 1'b0;
    chk("mid_rst_accepted", 32'(taken), 32'd1);
  endtask

endmodule
